// File: rtl/psk_pkg.sv
// Shared types and helpers for the multi-mode PSK modulator.
package psk_pkg;

  localparam logic MODE_QPSK = 1'b0;
  localparam logic MODE_BPSK = 1'b1;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_e;

  // Two's-complement negate of a w-bit value held sign-extended in 32 bits;
  // the most negative code maps to the most positive instead of wrapping.
  function automatic logic signed [31:0] sat_neg(input logic signed [31:0] x, input int w);
    logic signed [31:0] mn;
    mn = -(32'sd1 <<< (w - 1));
    return (x == mn) ? ~mn : -x;
  endfunction

endpackage

// File: rtl/psk_bit_delay.sv
// Tap-selectable shift-register delay for the symbol-bit monitor output.
module psk_bit_delay
#(
  parameter int DLY_W = 4
)(
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       din,
  input  logic [DLY_W-1:0] tap,
  output logic [1:0]       dout
);
  localparam int DEPTH = 2**DLY_W;

  logic [DEPTH-1:0][1:0] dl_q, dl_d;
  logic [DLY_W-1:0]      tap_q, tap_d;

  always_comb begin
    dl_d  = {dl_q[DEPTH-2:0], din};
    tap_d = tap;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dl_q  <= '0;
      tap_q <= '0;
    end else begin
      dl_q  <= dl_d;
      tap_q <= tap_d;
    end
  end

  // Tap 0 is the stage loaded alongside the modulated sample.
  assign dout = dl_q[tap_q];

endmodule

// File: rtl/psk_mod_multi.sv
// BPSK/QPSK modulator: AXIS words serialised MSB-first into symbols held for
// SPS clocks, sign-modulating the NCO carrier; mode chosen per frame.
module psk_mod_multi
  import psk_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int BYTES = 1,
  parameter int SPS   = 16,
  parameter int DLY_W = 4
)(
  input  logic                    clk_16d384M,
  input  logic                    rst_16d384M,
  input  logic [8*BYTES-1:0]      data_tdata,
  input  logic                    data_tvalid,
  output logic                    data_tready,
  input  logic                    data_tlast,
  input  logic                    data_tuser,
  input  logic signed [WIDTH-1:0] carrier_I,
  input  logic signed [WIDTH-1:0] carrier_Q,
  input  logic [DLY_W-1:0]        delay_cnt,
  output logic signed [WIDTH-1:0] out_I,
  output logic signed [WIDTH-1:0] out_Q,
  output logic                    out_vld,
  output logic                    out_last,
  output logic                    out_is_bpsk,
  output logic [1:0]              out_bits,
  output logic                    sym_stb
);
  localparam int W  = 8*BYTES;
  localparam int RW = $clog2(W+1);
  localparam int CW = $clog2(SPS);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W-1:0]     sreg_q, sreg_d, src;
  logic [RW-1:0]    rem_q, rem_d, avail, pbps, bps_cur;
  logic             last_w_q, last_w_d, user_w_q, user_w_d, mode_q, mode_d;
  logic [1:0]       bits_q, bits_d;
  logic             vld_q, vld_d, olast_q, olast_d, bpsk_q, bpsk_d, stb_q;
  logic signed [WIDTH-1:0] oi_q, oi_d, oq_q, oq_d;
  logic             boundary, hs, pop, pop_mode, last_sym;
  logic signed [31:0] ni, nq;

  assign boundary    = (cnt_q == CW'(SPS-1));
  assign bps_cur     = (mode_q == MODE_BPSK) ? RW'(1) : RW'(2);
  assign data_tready = ~rst_16d384M & ((rem_q == '0) | (boundary & (rem_q == bps_cur)));
  assign hs          = data_tvalid & data_tready;

  always_comb begin
    cnt_d    = boundary ? '0 : cnt_q + CW'(1);
    state_d  = state_q;
    sreg_d   = sreg_q;
    rem_d    = rem_q;
    last_w_d = last_w_q;
    user_w_d = user_w_q;
    mode_d   = mode_q;
    bits_d   = bits_q;
    vld_d    = vld_q;
    olast_d  = olast_q;
    bpsk_d   = bpsk_q;
    pop      = 1'b0;
    pop_mode = mode_q;
    src      = sreg_q;
    avail    = rem_q;
    pbps     = RW'(2);
    last_sym = 1'b0;

    if (hs) begin
      sreg_d   = data_tdata;
      rem_d    = RW'(W);
      last_w_d = data_tlast;
      // Only the first word of a frame carries a meaningful mode flag.
      if (state_q != RUN || last_w_q) user_w_d = data_tuser;
    end

    case (state_q)
      IDLE: if (hs) begin
        mode_d  = data_tuser;
        state_d = RUN;
      end
      RUN: if (boundary) begin
        if (rem_q == '0 && !hs) state_d = IDLE;
        else                    pop = 1'b1;
      end
      FLUSH: if (boundary) begin
        if (rem_q == '0 && !hs) state_d = IDLE;
        else begin
          pop      = 1'b1;
          pop_mode = (rem_q == '0) ? data_tuser : user_w_q;
          mode_d   = pop_mode;
          state_d  = RUN;
        end
      end
      default: state_d = IDLE;
    endcase

    if (boundary) begin
      vld_d   = 1'b0;
      olast_d = 1'b0;
      bits_d  = 2'b00;
    end

    // A word arriving on the boundary with an empty buffer is popped straight
    // from tdata so the symbol stream has no gap.
    if (pop) begin
      src   = (rem_q == '0) ? data_tdata : sreg_q;
      avail = (rem_q == '0) ? RW'(W) : rem_q;
      pbps  = (pop_mode == MODE_BPSK) ? RW'(1) : RW'(2);
      if (rem_q == '0 || !hs) begin
        sreg_d = src << pbps;
        rem_d  = avail - pbps;
      end
      last_sym = (rem_q == pbps) && last_w_q;
      if (last_sym) state_d = FLUSH;
      bits_d  = (pop_mode == MODE_BPSK) ? {2{src[W-1]}} : src[W-1 -: 2];
      vld_d   = 1'b1;
      olast_d = last_sym;
      bpsk_d  = pop_mode;
    end

    ni   = sat_neg(32'(carrier_I), WIDTH);
    nq   = sat_neg(32'(carrier_Q), WIDTH);
    oi_d = !vld_d ? '0 : (bits_d[1] ? ni[WIDTH-1:0] : carrier_I);
    oq_d = !vld_d ? '0 : (bits_d[0] ? nq[WIDTH-1:0] : carrier_Q);
  end

  always_ff @(posedge clk_16d384M or posedge rst_16d384M) begin
    if (rst_16d384M) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sreg_q   <= '0;
      rem_q    <= '0;
      last_w_q <= 1'b0;
      user_w_q <= 1'b0;
      mode_q   <= 1'b0;
      bits_q   <= '0;
      vld_q    <= 1'b0;
      olast_q  <= 1'b0;
      bpsk_q   <= 1'b0;
      stb_q    <= 1'b0;
      oi_q     <= '0;
      oq_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sreg_q   <= sreg_d;
      rem_q    <= rem_d;
      last_w_q <= last_w_d;
      user_w_q <= user_w_d;
      mode_q   <= mode_d;
      bits_q   <= bits_d;
      vld_q    <= vld_d;
      olast_q  <= olast_d;
      bpsk_q   <= bpsk_d;
      stb_q    <= boundary;
      oi_q     <= oi_d;
      oq_q     <= oq_d;
    end
  end

  psk_bit_delay #(.DLY_W(DLY_W)) u_dly (
    .clk  (clk_16d384M),
    .rst  (rst_16d384M),
    .din  (bits_d),
    .tap  (delay_cnt),
    .dout (out_bits)
  );

  assign out_I       = oi_q;
  assign out_Q       = oq_q;
  assign out_vld     = vld_q;
  assign out_last    = olast_q;
  assign out_is_bpsk = bpsk_q;
  assign sym_stb     = stb_q;

endmodule

// File: doc/psk_mod_multi.md
Name: psk_mod_multi

Overview:
Parametrised successor to the fixed BPSK/QPSK modulator core on the 16.384 MHz domain. Consumes an AXI-Stream byte/word stream (post-CDC FIFO), serialises it MSB-first into BPSK (1 bit/sym) or QPSK (2 bits/sym) symbols held for SPS clocks, and applies sign modulation to the NCO carrier I/Q. Mode is selectable per frame. A programmable delay line aligns the bit-monitor output with the modulated samples for the DAC/ILA path.

Parameters:
WIDTH, 12, carrier and DAC sample width (signed two's complement)
BYTES, 1, tdata width in bytes; word = 8*BYTES bits
SPS, 16, clocks per symbol (16 -> 1.024 Msym/s at 16.384 MHz); must be >= 2
DLY_W, 4, width of delay_cnt; delay line depth = 2^DLY_W

Ports:
clk_16d384M  in  1  sole clock
rst_16d384M  in  1  asynchronous, active-high reset
data_tdata  in  8*BYTES  payload word, MSB transmitted first
data_tvalid  in  1  AXIS valid
data_tready  out  1  AXIS ready
data_tlast  in  1  last word of frame
data_tuser  in  1  on first word of frame: 1 = BPSK frame, 0 = QPSK frame
carrier_I  in  WIDTH  NCO cosine, signed
carrier_Q  in  WIDTH  NCO sine, signed
delay_cnt  in  DLY_W  out_bits delay in clocks, sampled every cycle
out_I  out  WIDTH  modulated I
out_Q  out  WIDTH  modulated Q
out_vld  out  1  sample carries a symbol
out_last  out  1  high during the final symbol of a frame
out_is_bpsk  out  1  current frame mode
out_bits  out  2  current symbol bits {bI,bQ} (BPSK: {b,b}), delayed by delay_cnt
sym_stb  out  1  one-clock pulse on each symbol boundary

Behaviour:
- Reset (async, any time): all outputs 0; symbol counter 0; shift register empty; FSM IDLE; delay line cleared. data_tready = 0 during reset.
- Symbol counter cnt runs 0..SPS-1 continuously; boundary = cnt==SPS-1. sym_stb asserts on the cycle after the boundary (registered).
- Word buffer: one word shift register sreg plus bit count rem. data_tready = 1 when rem==0 or (boundary and rem==bits_per_sym); a handshake (tvalid&tready) loads sreg, rem = 8*BYTES, and latches tlast into last_w.
- FSM: IDLE -> on first handshake, latch mode = tuser; go RUN. RUN: at each boundary pop bits_per_sym MSBs from sreg into sym register. If rem==0 at a boundary and no word available: underrun -> IDLE (out_vld drops at next symbol start). After popping the last symbol of a word with last_w=1 -> FLUSH: hold that symbol for its SPS clocks with out_last=1, then IDLE. tuser on non-first words is ignored.
- Mode change only takes effect at frame start; a frame starting immediately after FLUSH begins on the next boundary with no gap symbol.
- Mapping: bit 1 -> negate, bit 0 -> pass. BPSK: out_I = s(b)*carrier_I, out_Q = s(b)*carrier_Q. QPSK: out_I = s(bI)*carrier_I, out_Q = s(bQ)*carrier_Q, bI = first (MSB) bit.
- Negation saturates: -(-2^(WIDTH-1)) = 2^(WIDTH-1)-1.
- Latency: carrier_* to out_* = 1 clock (registered). Symbol bits popped at boundary appear on out_* one clock later, aligned with sym_stb.
- IDLE: out_I = out_Q = 0, out_vld = 0, out_last = 0; out_is_bpsk holds last frame mode.
- BYTES*8 not a multiple of 2 cannot occur; QPSK consumes a word in 4*BYTES symbols, BPSK in 8*BYTES.
- out_bits: shift-register delay line of depth 2^DLY_W, tap selected by delay_cnt (0 = undelayed registered value); delay_cnt change takes effect next clock, no glitch beyond tap switch.

Decomposition:
- Package psk_pkg: mode constants (MODE_QPSK=0, MODE_BPSK=1), FSM state enum (IDLE, RUN, FLUSH), saturating-negate function.
- One sub-module: psk_bit_delay (parametrised tap delay line for out_bits).

Test Plan:
- BPSK frame, BYTES=1, tdata=0xA5, tuser=1, tlast=1, carrier_I=100, carrier_Q=50 -> 8 symbols x 16 clk; out_I = -100,+100,-100,+100,+100,-100,+100,-100; out_last high on the 8th symbol only; then IDLE, out_vld=0.
- QPSK frame 0x1B, tuser=0 -> symbols {00,01,10,11}; (out_I,out_Q) = (100,50),(100,-50),(-100,50),(-100,-50); 64 clocks total.
- Saturation: carrier_I=-2048, bit=1 -> out_I=2047.
- Back-to-back frames (BPSK then QPSK, tvalid held) -> no idle symbol between; out_is_bpsk switches exactly at the first QPSK symbol.
- Underrun: stall tvalid after first word of a 2-word frame -> out_vld falls at the next symbol start, FSM IDLE; resume -> new word treated as frame start (tuser re-sampled).
- delay_cnt=5 -> out_bits equals the undelayed sequence shifted by 5 clocks; async reset asserted mid-symbol -> all outputs 0 immediately, tready=0.
